// File: rtl/clock_pkg.sv
// Shared clock/alarm types: state encoding, BCD limits
// and the hh:mm digit bundle.
package clock_pkg;

  localparam int DIGIT_W             = 4;
  localparam int MIN_TENS_MAX        = 5;
  localparam int HOUR_TENS_MAX       = 2;
  localparam int HOUR_UNITS_MAX_AT_2 = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RINGING = 2'b01,
    ST_SNOOZE  = 2'b10
  } state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] h1;
    logic [DIGIT_W-1:0] h0;
    logic [DIGIT_W-1:0] m1;
    logic [DIGIT_W-1:0] m0;
  } hhmm_t;

endpackage

// File: rtl/bcd_time_add.sv
// Combinational hh:mm + 0..9 minutes in BCD,
// wrapping 59->00 minutes and 23->00 hours.
module bcd_time_add
  import clock_pkg::*;
(
  input  hhmm_t              t,
  input  logic [DIGIT_W-1:0] add,
  output hhmm_t              sum
);

  localparam logic [7:0] MIN_PER_HR =
    8'((MIN_TENS_MAX + 1) * 10);

  logic [7:0] mins;
  logic [7:0] mins_w;
  logic       carry;

  always_comb begin
    mins   = 8'(t.m1) * 8'd10
           + 8'(t.m0) + 8'(add);
    carry  = (mins >= MIN_PER_HR);
    mins_w = carry ? mins - MIN_PER_HR : mins;
    sum.m1 = 4'(mins_w / 8'd10);
    sum.m0 = 4'(mins_w % 8'd10);
    sum.h1 = t.h1;
    sum.h0 = t.h0;
    if (carry) begin
      if (t.h1 == 4'(HOUR_TENS_MAX) &&
          t.h0 == 4'(HOUR_UNITS_MAX_AT_2)) begin
        sum.h1 = '0;
        sum.h0 = '0;
      end else if (t.h0 == 4'd9) begin
        sum.h1 = t.h1 + 4'd1;
        sum.h0 = '0;
      end else begin
        sum.h0 = t.h0 + 4'd1;
      end
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// Alarm target compare, ring timeout and snooze
// sequencing between timekeeper and buzzer.
module alarm_controller
  import clock_pkg::*;
#(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SECS  = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic [3:0] t_h1,
  input  logic [3:0] t_h0,
  input  logic [3:0] t_m1,
  input  logic [3:0] t_m0,
  input  logic [3:0] a_h1,
  input  logic [3:0] a_h0,
  input  logic [3:0] a_m1,
  input  logic [3:0] a_m0,
  input  logic       alarm_en,
  input  logic       snooze_n,
  input  logic       stop_n,
  output logic       ring,
  output logic       snoozing,
  output logic [1:0] state,
  output logic [3:0] g_h1,
  output logic [3:0] g_h0,
  output logic [3:0] g_m1,
  output logic [3:0] g_m0
);

  state_t     st, st_n;
  hhmm_t      t, a, g, g_n, g_snz;
  logic [7:0] cnt, cnt_n;
  logic       match, match_q, hit;
  logic       snooze_q, stop_q;
  logic       snz_p, stop_p;

  assign t = {t_h1, t_h0, t_m1, t_m0};
  assign a = {a_h1, a_h0, a_m1, a_m0};

  assign match  = (t == g);
  assign hit    = match & ~match_q;
  assign snz_p  = snooze_q & ~snooze_n;
  assign stop_p = stop_q & ~stop_n;

  bcd_time_add u_snz (
    .t   (g),
    .add (4'(SNOOZE_MIN)),
    .sum (g_snz)
  );

  // match_q starts high so a reset with t == target
  // does not look like a fresh match.
  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= ST_IDLE;
      g        <= '0;
      cnt      <= '0;
      match_q  <= 1'b1;
      snooze_q <= 1'b1;
      stop_q   <= 1'b1;
    end else begin
      st       <= st_n;
      g        <= g_n;
      cnt      <= cnt_n;
      match_q  <= match;
      snooze_q <= snooze_n;
      stop_q   <= stop_n;
    end
  end

  always_comb begin
    st_n  = st;
    g_n   = g;
    cnt_n = cnt;
    if (st == ST_IDLE) g_n = a;
    if (!alarm_en) begin
      st_n  = ST_IDLE;
      cnt_n = '0;
    end else begin
      unique case (st)
        ST_IDLE: begin
          if (hit) begin
            st_n  = ST_RINGING;
            cnt_n = '0;
          end
        end
        ST_RINGING: begin
          if (stop_p) begin
            st_n = ST_IDLE;
          end else if (snz_p) begin
            st_n  = ST_SNOOZE;
            g_n   = g_snz;
            cnt_n = '0;
          end else if (sec_tick) begin
            if (cnt == 8'(RING_SECS - 1))
              st_n = ST_IDLE;
            else
              cnt_n = cnt + 8'd1;
          end
        end
        ST_SNOOZE: begin
          if (stop_p) begin
            st_n = ST_IDLE;
          end else if (hit) begin
            st_n  = ST_RINGING;
            cnt_n = '0;
          end
        end
        default: st_n = ST_IDLE;
      endcase
    end
  end

  assign ring     = (st == ST_RINGING);
  assign snoozing = (st == ST_SNOOZE);
  assign state    = st;
  assign g_h1     = g.h1;
  assign g_h0     = g.h0;
  assign g_m1     = g.m1;
  assign g_m0     = g.m0;

endmodule

// File: tb/tb_alarm_controller.sv
// Scenario bench for alarm_controller: expected
// snapshots queued and compared against observations.
module tb_alarm_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        sec_tick;
  logic [15:0] tt, aa;
  logic        alarm_en, snooze_n, stop_n;
  logic        ring, snoozing;
  logic [1:0]  state;
  logic [3:0]  g_h1, g_h0, g_m1, g_m0;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string       name;
    logic [19:0] v;
  } exp_t;

  exp_t        exp_q[$];
  logic [19:0] obs_q[$];

  always #5 clk = ~clk;

  alarm_controller #(
    .SNOOZE_MIN (5),
    .RING_SECS  (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sec_tick (sec_tick),
    .t_h1     (tt[15:12]),
    .t_h0     (tt[11:8]),
    .t_m1     (tt[7:4]),
    .t_m0     (tt[3:0]),
    .a_h1     (aa[15:12]),
    .a_h0     (aa[11:8]),
    .a_m1     (aa[7:4]),
    .a_m0     (aa[3:0]),
    .alarm_en (alarm_en),
    .snooze_n (snooze_n),
    .stop_n   (stop_n),
    .ring     (ring),
    .snoozing (snoozing),
    .state    (state),
    .g_h1     (g_h1),
    .g_h0     (g_h0),
    .g_m1     (g_m1),
    .g_m0     (g_m0)
  );

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Queue the expected view and capture the DUT view.
  task automatic snap(input string n,
                      input logic [1:0] s,
                      input logic [15:0] g);
    exp_t e;
    e.name = n;
    e.v = {s, s == 2'b01, s == 2'b10, g};
    exp_q.push_back(e);
    obs_q.push_back({state, ring, snoozing,
                     g_h1, g_h0, g_m1, g_m0});
  endtask

  task automatic ring_at(input logic [15:0] at);
    aa = at;
    tt = at - 16'h0001;
    cyc(2);
    tt = at;
    cyc();
  endtask

  task automatic press_stop();
    stop_n = 1'b0;
    cyc();
    stop_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    exp_t e;
    logic [19:0] o;
    reset = 1'b1; sec_tick = 1'b0;
    alarm_en = 1'b0; snooze_n = 1'b1; stop_n = 1'b1;
    tt = 16'h0000; aa = 16'h0000;
    cyc(2);
    snap("reset_vals", 2'b00, 16'h0000);
    reset = 1'b0; alarm_en = 1'b1;
    cyc(3);
    snap("reset_exit_no_ring", 2'b00, 16'h0000);
    tt = 16'h0001;
    cyc();
    tt = 16'h0000;
    cyc();
    snap("rematch_rings", 2'b01, 16'h0000);
    press_stop();
    snap("stop_idle", 2'b00, 16'h0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++;
      if (o !== e.v)
        $display("FAIL %s: got %h want %h", e.name, o, e.v);
      else passed++;
    end
  endtask

  task automatic test_arm_hit();
    exp_t e;
    logic [19:0] o;
    aa = 16'h0730; tt = 16'h0729;
    cyc(2);
    snap("armed_target", 2'b00, 16'h0730);
    tt = 16'h0730;
    #1;
    snap("hit_cycle_idle", 2'b00, 16'h0730);
    cyc();
    snap("ring_next_cycle", 2'b01, 16'h0730);
    press_stop();
    cyc(3);
    snap("no_retrigger_stop", 2'b00, 16'h0730);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++;
      if (o !== e.v)
        $display("FAIL %s: got %h want %h", e.name, o, e.v);
      else passed++;
    end
  endtask

  task automatic test_snooze_wrap();
    exp_t e;
    logic [19:0] o;
    ring_at(16'h2358);
    snap("ring_2358", 2'b01, 16'h2358);
    snooze_n = 1'b0;
    cyc();
    snap("snooze_wrap", 2'b10, 16'h0003);
    cyc();
    snooze_n = 1'b1;
    cyc();
    snap("snooze_held", 2'b10, 16'h0003);
    tt = 16'h0003;
    cyc();
    snap("snooze_rering", 2'b01, 16'h0003);
    press_stop();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++;
      if (o !== e.v)
        $display("FAIL %s: got %h want %h", e.name, o, e.v);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    logic [19:0] o;
    ring_at(16'h1200);
    for (int i = 0; i < 3; i++) begin
      sec_tick = 1'b1;
      cyc();
      sec_tick = 1'b0;
      cyc();
      snap($sformatf("tick_%0d", i + 1),
           (i == 2) ? 2'b00 : 2'b01, 16'h1200);
    end
    cyc(4);
    snap("timeout_no_retrigger", 2'b00, 16'h1200);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++;
      if (o !== e.v)
        $display("FAIL %s: got %h want %h", e.name, o, e.v);
      else passed++;
    end
  endtask

  task automatic test_stop_beats_snooze();
    exp_t e;
    logic [19:0] o;
    ring_at(16'h0645);
    stop_n = 1'b0; snooze_n = 1'b0;
    aa = 16'h0700;
    cyc();
    snap("stop_over_snooze", 2'b00, 16'h0645);
    cyc();
    snap("reload_after_stop", 2'b00, 16'h0700);
    stop_n = 1'b1; snooze_n = 1'b1;
    cyc();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++;
      if (o !== e.v)
        $display("FAIL %s: got %h want %h", e.name, o, e.v);
      else passed++;
    end
  endtask

  task automatic test_disarm_snooze();
    exp_t e;
    logic [19:0] o;
    ring_at(16'h0957);
    snooze_n = 1'b0;
    cyc();
    snooze_n = 1'b1;
    snap("snooze_hour_carry", 2'b10, 16'h1002);
    cyc();
    alarm_en = 1'b0;
    cyc();
    snap("disarm_idle", 2'b00, 16'h1002);
    cyc();
    snap("disarm_reload", 2'b00, 16'h0957);
    alarm_en = 1'b1;
    tt = 16'h1002;
    cyc(3);
    snap("snoozed_target_gone", 2'b00, 16'h0957);
    reset = 1'b1;
    ring_at(16'h0100);
    snap("held_in_reset", 2'b00, 16'h0000);
    reset = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++;
      if (o !== e.v)
        $display("FAIL %s: got %h want %h", e.name, o, e.v);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_arm_hit();
    test_snooze_wrap();
    test_timeout();
    test_stop_beats_snooze();
    test_disarm_snooze();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
